alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 20 ++
 rtl/alu_res_fifo.sv | 50 +++++
 rtl/alu_issue_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU definitions: opcode encoding and ALU pipeline latency used by
// the issue controller and its result buffer.
package alu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ZERO = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_NOT  = 3'b011,
    OP_XOR  = 3'b100,
    OP_ABS  = 3'b101,
    OP_HSUB = 3'b110,
    OP_ADD  = 3'b111
  } alu_op_e;

  localparam int ALU_LATENCY = 2;
  // Issue register plus one tracking stage per ALU register stage.
  localparam int PIPE_STAGES = ALU_LATENCY + 1;

endpackage

// File: rtl/alu_res_fifo.sv
// Circular result buffer holding {data, tag} entries in completion order.
// The head reads as zero while empty so consumers never see stale entries.
module alu_res_fifo #(
  parameter int RES_DEPTH = 4,
  parameter int WIDTH     = 20
) (
  input  logic                       clk_p_i,
  input  logic                       reset_n_i,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(RES_DEPTH):0] count
);

  localparam int PTR_W = $clog2(RES_DEPTH);

  logic [WIDTH-1:0] mem [RES_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;

  assign rd_valid = (count != '0);
  assign do_rd    = rd_en & rd_valid;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk_p_i) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external 2-cycle ALU: registers operands, tracks
// in-flight tags, and buffers results with credit-based flow control.
module alu_issue_ctrl #(
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk_p_i,
  input  logic             reset_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [7:0]       cmd_a_i,
  input  logic [7:0]       cmd_b_i,
  input  logic [2:0]       cmd_inst_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  output logic [2:0]       alu_inst_o,
  input  logic [15:0]      alu_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [15:0]      res_data_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             busy_o
);

  import alu_issue_ctrl_pkg::*;

  localparam int CNT_W = $clog2(RES_DEPTH) + 1;
  localparam int ENT_W = 16 + TAG_W;

  logic                   accept;
  logic                   pop;
  logic [CNT_W-1:0]       credits;
  logic [PIPE_STAGES-1:0] pipe_v;
  logic [TAG_W-1:0]       pipe_tag [PIPE_STAGES];
  logic [ENT_W-1:0]       head;
  logic [CNT_W-1:0]       fifo_count;

  // Ready comes only from the registered credit count, never from the consumer.
  assign cmd_ready_o = (credits != '0);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign pop         = res_valid_o & res_ready_i;
  assign busy_o      = (|pipe_v) | (fifo_count != '0);
  assign res_data_o  = head[ENT_W-1:TAG_W];
  assign res_tag_o   = head[TAG_W-1:0];

  // A credit reserves a buffer slot from accept until that result is popped.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits <= CNT_W'(RES_DEPTH);
    end else if (accept && !pop) begin
      credits <= credits - 1'b1;
    end else if (pop && !accept) begin
      credits <= credits + 1'b1;
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      alu_a_o    <= '0;
      alu_b_o    <= '0;
      alu_inst_o <= OP_ZERO;
    end else if (accept) begin
      alu_a_o    <= cmd_a_i;
      alu_b_o    <= cmd_b_i;
      alu_inst_o <= cmd_inst_i;
    end else begin
      alu_a_o    <= '0;
      alu_b_o    <= '0;
      alu_inst_o <= OP_ZERO;
    end
  end

  // Valid/tag shadow of the ALU pipeline; it never stalls since credits
  // guarantee a free buffer slot for every op it carries.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pipe_v <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_v      <= {pipe_v[PIPE_STAGES-2:0], accept};
      pipe_tag[0] <= accept ? cmd_tag_i : '0;
      for (int i = 1; i < PIPE_STAGES; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  alu_res_fifo #(
    .RES_DEPTH (RES_DEPTH),
    .WIDTH     (ENT_W)
  ) u_res_fifo (
    .clk_p_i   (clk_p_i),
    .reset_n_i (reset_n_i),
    .wr_en     (pipe_v[PIPE_STAGES-1]),
    .wr_data   ({alu_data_i, pipe_tag[PIPE_STAGES-1]}),
    .rd_en     (pop),
    .rd_valid  (res_valid_o),
    .rd_data   (head),
    .count     (fifo_count)
  );

endmodule
